// File: rtl/fetch_seq.sv
// fetch_seq: program counter and instruction-fetch sequencer for the SISC core.
// Fetches a word from instruction memory over a req/ack handshake, latches it
// into ir, pulses ir_valid, then waits for the datapath to finish before
// stepping, branching or halting.
// Optional build macro FETCH_TIMEOUT_EN: adds a fetch-wait limit of
// TIMEOUT_CYCLES; on expiry the sequencer halts with fetch_err set.
module fetch_seq #(
   parameter int                  PC_WIDTH       = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
   parameter int                  TIMEOUT_CYCLES = 15
) (
   input  logic                clk,
   input  logic                rst_f,
   output logic                im_req,
   output logic [PC_WIDTH-1:0] im_addr,
   input  logic                im_ack,
   input  logic [31:0]         im_data,
   output logic [31:0]         ir,
   output logic                ir_valid,
   input  logic                exec_done,
   input  logic                br_taken,
   input  logic [PC_WIDTH-1:0] br_addr,
   input  logic                halt_op,
   input  logic                restart,
   output logic [PC_WIDTH-1:0] pc,
   output logic                halted,
   output logic                fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         ir_q, ir_d;
   logic                im_req_q, im_req_d;
   logic                ir_valid_q, ir_valid_d;
   logic                halted_q, halted_d;
   logic                fetch_err_q, fetch_err_d;

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_q, wait_d;
`else
   // Limit only matters when the timeout is built in.
   logic unused_cfg;
   assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

   // Next-state and registered-output computation; every output flop is set
   // on the transition into the state that owns it, so outputs never depend
   // combinationally on inputs.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      im_req_d    = im_req_q;
      ir_valid_d  = 1'b0;
      halted_d    = halted_q;
      fetch_err_d = fetch_err_q;
`ifdef FETCH_TIMEOUT_EN
      wait_d      = wait_q;
`endif
      case (state_q)
         S_IDLE: begin
            state_d  = S_FETCH;
            im_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_d   = '0;
`endif
         end
         S_FETCH: begin
            if (im_ack) begin
               ir_d       = im_data;
               state_d    = S_ISSUE;
               im_req_d   = 1'b0;
               ir_valid_d = 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            // An ack on the limit cycle takes the branch above and wins.
            else if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d     = S_HALT;
               im_req_d    = 1'b0;
               halted_d    = 1'b1;
               fetch_err_d = 1'b1;
            end else begin
               wait_d = wait_q + CW'(1);
            end
`endif
         end
         S_ISSUE: state_d = S_EXEC;
         S_EXEC: begin
            if (exec_done) begin
               if (halt_op) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d     = br_taken ? br_addr : pc_q + 1'b1;
                  state_d  = S_FETCH;
                  im_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                  wait_d   = '0;
`endif
               end
            end
         end
         S_HALT: begin
            if (restart) begin
               pc_d        = pc_q + 1'b1;
               halted_d    = 1'b0;
               fetch_err_d = 1'b0;
               state_d     = S_FETCH;
               im_req_d    = 1'b1;
`ifdef FETCH_TIMEOUT_EN
               wait_d      = '0;
`endif
            end
         end
         default: begin
            state_d  = S_IDLE;
            im_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset is asynchronous so im_req drops at once.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         im_req_q    <= 1'b0;
         ir_valid_q  <= 1'b0;
         halted_q    <= 1'b0;
         fetch_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wait_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         im_req_q    <= im_req_d;
         ir_valid_q  <= ir_valid_d;
         halted_q    <= halted_d;
         fetch_err_q <= fetch_err_d;
`ifdef FETCH_TIMEOUT_EN
         wait_q      <= wait_d;
`endif
      end
   end

   assign im_req    = im_req_q;
   assign im_addr   = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign halted    = halted_q;
   assign fetch_err = fetch_err_q;

endmodule
